// File: rtl/mod_signal_gen_multi_if.sv
// Configuration bus for mod_signal_gen_multi: staged waveform settings and the
// one-cycle acknowledge returned when a staged set becomes active.
interface mod_signal_gen_multi_if #(
   parameter int CNT_W     = 8,
   parameter int NUM_LIGHT = 2,
   parameter int DEAD_W    = 4
);
   logic                       CFG_LOAD;
   logic [CNT_W-1:0]           PERIOD;
   logic [CNT_W-1:0]           HIGH_CNT;
   logic [DEAD_W-1:0]          DEAD;
   logic [NUM_LIGHT*CNT_W-1:0] PHASE;
   logic                       CFG_ACK;

   modport master (output CFG_LOAD, PERIOD, HIGH_CNT, DEAD, PHASE, input  CFG_ACK);
   modport slave  (input  CFG_LOAD, PERIOD, HIGH_CNT, DEAD, PHASE, output CFG_ACK);
endinterface

// File: rtl/mod_signal_gen_multi.sv
// Multi-output modulation clock generator: MOD, non-overlapping MODN and
// phase-shifted light clocks, with glitch-free reconfiguration at period wrap.
module mod_signal_gen_multi_lane #(
   parameter int CNT_W = 8
) (
   input  logic [CNT_W:0]   cnt_i,
   input  logic [CNT_W:0]   p_i,
   input  logic [CNT_W:0]   h_i,
   input  logic [CNT_W-1:0] ph_i,
   output logic             on_o
);
   localparam logic [CNT_W:0] ONE = 1;
   logic [CNT_W:0] ph_c;
   logic [CNT_W:0] rel;

   // (cnt - ph) mod P without a divider: ph <= P-1, so one conditional add suffices
   always_comb begin
      ph_c = ({1'b0, ph_i} >= p_i) ? (p_i - ONE) : {1'b0, ph_i};
      rel  = (cnt_i >= ph_c) ? (cnt_i - ph_c) : (cnt_i + p_i - ph_c);
      on_o = (rel < h_i);
   end
endmodule

module mod_signal_gen_multi #(
   parameter int CNT_W     = 8,
   parameter int NUM_LIGHT = 2,
   parameter int DEAD_W    = 4
) (
   input  logic                     CLK_IN,
   input  logic                     RESET_B,
   input  logic                     ENABLE,
   mod_signal_gen_multi_if.slave    cfg,
   output logic                     CLK_OUT_MOD,
   output logic                     CLK_OUT_MODN,
   output logic [NUM_LIGHT-1:0]     CLK_OUT_MODL,
   output logic                     PERIOD_START
);
   localparam int W1 = CNT_W + 1;
   localparam logic [W1-1:0]    ONE_W   = 1;
   localparam logic [W1-1:0]    TWO_W   = 2;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   typedef struct packed {
      logic [CNT_W-1:0]           per;
      logic [CNT_W-1:0]           high;
      logic [DEAD_W-1:0]          dead;
      logic [NUM_LIGHT*CNT_W-1:0] phase;
   } cfg_t;

   localparam cfg_t CFG_RST = '{per: CNT_ONE, high: CNT_ONE, dead: '0, phase: '0};

   logic [1:0]           rst_sync_q;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   cfg_t                 act_q, act_d;
   cfg_t                 stg_q, stg_d;
   logic                 pend_q, pend_d;
   logic                 mod_q, mod_d;
   logic                 modn_q, modn_d;
   logic [NUM_LIGHT-1:0] modl_q, modl_d;
   logic                 pstart_q, pstart_d;
   logic                 ack_q, ack_d;

   logic [W1-1:0]        p_w, h_w, d_w, cnt_w, lo_w, hi_w;
   logic                 run, wrap, apply;
   logic [NUM_LIGHT-1:0] lane_on;

   // Only the release edge is synchronised; assertion still clears everything at once
   always_ff @(posedge CLK_IN or negedge RESET_B) begin
      if (!RESET_B) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end

   always_comb begin
      p_w   = (act_q.per == '0) ? TWO_W : ({1'b0, act_q.per} + ONE_W);
      h_w   = ({1'b0, act_q.high} > p_w) ? p_w : {1'b0, act_q.high};
      d_w   = W1'(act_q.dead);
      cnt_w = {1'b0, cnt_q};
      lo_w  = h_w + d_w;
      hi_w  = (d_w >= p_w) ? '0 : (p_w - d_w);
      run   = (state_q != IDLE);
      wrap  = (cnt_w == (p_w - ONE_W));
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LIGHT; gi++) begin : g_lane
         mod_signal_gen_multi_lane #(.CNT_W(CNT_W)) u_lane (
            .cnt_i (cnt_w),
            .p_i   (p_w),
            .h_i   (h_w),
            .ph_i  (act_q.phase[gi*CNT_W +: CNT_W]),
            .on_o  (lane_on[gi])
         );
      end
   endgenerate

   always_comb begin
      // A load in the apply cycle wins: the apply is deferred to the next opportunity
      apply   = pend_q && (!run || wrap) && !cfg.CFG_LOAD;
      state_d = state_q;
      cnt_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (ENABLE && rst_sync_q[1]) state_d = RUN;
         end
         RUN: begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
            if (!ENABLE) state_d = DRAIN;
         end
         DRAIN: begin
            cnt_d = wrap ? '0 : (cnt_q + CNT_ONE);
            if (ENABLE)    state_d = RUN;
            else if (wrap) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      act_d  = apply ? stg_q : act_q;
      stg_d  = cfg.CFG_LOAD ? cfg_t'({cfg.PERIOD, cfg.HIGH_CNT, cfg.DEAD, cfg.PHASE}) : stg_q;
      pend_d = cfg.CFG_LOAD | (pend_q & ~apply);

      mod_d    = run && (cnt_w < h_w);
      modn_d   = run && (cnt_w >= lo_w) && (cnt_w < hi_w);
      modl_d   = run ? lane_on : '0;
      pstart_d = run && (cnt_q == '0);
      ack_d    = apply;
   end

   always_ff @(posedge CLK_IN or negedge RESET_B) begin
      if (!RESET_B) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         act_q    <= CFG_RST;
         stg_q    <= '0;
         pend_q   <= 1'b0;
         mod_q    <= 1'b0;
         modn_q   <= 1'b0;
         modl_q   <= '0;
         pstart_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         act_q    <= act_d;
         stg_q    <= stg_d;
         pend_q   <= pend_d;
         mod_q    <= mod_d;
         modn_q   <= modn_d;
         modl_q   <= modl_d;
         pstart_q <= pstart_d;
         ack_q    <= ack_d;
      end
   end

   assign CLK_OUT_MOD  = mod_q;
   assign CLK_OUT_MODN = modn_q;
   assign CLK_OUT_MODL = modl_q;
   assign PERIOD_START = pstart_q;
   assign cfg.CFG_ACK  = ack_q;
endmodule

// File: tb/tb_mod_signal_gen_multi.sv
// Self-checking bench for mod_signal_gen_multi: directed scenarios plus a random
// soak, all compared each cycle against a behavioural model of the waveform rules.
module tb_mod_signal_gen_multi;
   localparam int CNT_W = 8, NUM_LIGHT = 2, DEAD_W = 4;
   localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
   logic mod_o, modn_o, ps_o;
   logic [NUM_LIGHT-1:0] modl_o;
   int n_chk = 0, n_err = 0;

   mod_signal_gen_multi_if #(.CNT_W(CNT_W), .NUM_LIGHT(NUM_LIGHT), .DEAD_W(DEAD_W)) cfg_if();

   mod_signal_gen_multi #(.CNT_W(CNT_W), .NUM_LIGHT(NUM_LIGHT), .DEAD_W(DEAD_W)) dut (
      .CLK_IN(clk), .RESET_B(rst_n), .ENABLE(enable), .cfg(cfg_if),
      .CLK_OUT_MOD(mod_o), .CLK_OUT_MODN(modn_o), .CLK_OUT_MODL(modl_o), .PERIOD_START(ps_o)
   );

   always #5 clk = ~clk;

   // model state: period position, mode, active/staged settings as plain integers
   int m_mode, m_cnt, m_sync, m_pend;
   int a_per, a_high, a_dead, s_per, s_high, s_dead;
   int a_ph[NUM_LIGHT], s_ph[NUM_LIGHT];
   logic e_mod, e_modn, e_ps, e_ack;
   logic [NUM_LIGHT-1:0] e_modl;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_cnt = 0; m_sync = 0; m_pend = 0;
      a_per = 1; a_high = 1; a_dead = 0;
      s_per = 0; s_high = 0; s_dead = 0;
      for (int i = 0; i < NUM_LIGHT; i++) begin a_ph[i] = 0; s_ph[i] = 0; end
   endtask

   // one clock: predict outputs from model state, advance model, compare after edge
   task automatic tick();
      int p, h, ph, nm, nc;
      bit wrap, apply, ld;
      p  = (a_per == 0) ? 2 : a_per + 1;
      h  = (a_high < p) ? a_high : p;
      ld = cfg_if.CFG_LOAD;
      e_mod = 0; e_modn = 0; e_ps = 0; e_modl = '0;
      if (m_mode != M_IDLE) begin
         e_mod  = (m_cnt < h);
         e_modn = (m_cnt >= h + a_dead) && (m_cnt < p - a_dead);
         e_ps   = (m_cnt == 0);
         for (int i = 0; i < NUM_LIGHT; i++) begin
            ph = (a_ph[i] >= p) ? p - 1 : a_ph[i];
            e_modl[i] = (((m_cnt - ph + p) % p) < h);
         end
      end
      wrap  = (m_cnt == p - 1);
      apply = m_pend && (m_mode == M_IDLE || wrap) && !ld;
      e_ack = apply;
      nm = m_mode;
      nc = (m_mode == M_IDLE) ? 0 : (wrap ? 0 : m_cnt + 1);
      if (m_mode == M_IDLE && enable && m_sync >= 2) nm = M_RUN;
      else if (m_mode == M_RUN && !enable) nm = M_DRAIN;
      else if (m_mode == M_DRAIN) nm = enable ? M_RUN : (wrap ? M_IDLE : M_DRAIN);
      if (apply) begin
         a_per = s_per; a_high = s_high; a_dead = s_dead;
         for (int i = 0; i < NUM_LIGHT; i++) a_ph[i] = s_ph[i];
      end
      if (ld) begin
         s_per = cfg_if.PERIOD; s_high = cfg_if.HIGH_CNT; s_dead = cfg_if.DEAD;
         for (int i = 0; i < NUM_LIGHT; i++) s_ph[i] = cfg_if.PHASE[i*CNT_W +: CNT_W];
      end
      m_pend = ld ? 1 : (apply ? 0 : m_pend);
      if (m_sync < 2) m_sync++;
      m_mode = nm; m_cnt = nc;
      @(posedge clk);
      @(negedge clk);
      chk("MOD", mod_o, e_mod);
      chk("MODN", modn_o, e_modn);
      chk("MODL", modl_o, e_modl);
      chk("PSTART", ps_o, e_ps);
      chk("ACK", cfg_if.CFG_ACK, e_ack);
      chk("EXCL", mod_o & modn_o, 0);
   endtask

   task automatic set_cfg(input int per, input int high, input int dead, input int ph0, input int ph1);
      cfg_if.PERIOD   = CNT_W'(per);
      cfg_if.HIGH_CNT = CNT_W'(high);
      cfg_if.DEAD     = DEAD_W'(dead);
      cfg_if.PHASE    = {CNT_W'(ph1), CNT_W'(ph0)};
   endtask

   task automatic load_now(input int per, input int high, input int dead, input int ph0, input int ph1);
      set_cfg(per, high, dead, ph0, ph1);
      cfg_if.CFG_LOAD = 1'b1;
      tick();
      cfg_if.CFG_LOAD = 1'b0;
   endtask

   task automatic ticks_to_ack(output int k);
      k = 0;
      while (!cfg_if.CFG_ACK && k < 300) begin tick(); k++; end
      if (!cfg_if.CFG_ACK) chk("ACK_TIMEOUT", cfg_if.CFG_ACK, 1);
   endtask

   task automatic load_cfg(input int per, input int high, input int dead, input int ph0, input int ph1);
      int k;
      load_now(per, high, dead, ph0, ph1);
      ticks_to_ack(k);
   endtask

   task automatic wait_ps();
      int k;
      k = 0;
      while (!ps_o && k < 300) begin tick(); k++; end
      if (!ps_o) chk("PS_TIMEOUT", ps_o, 1);
   endtask

   task automatic ticks_to_ps(output int k);
      k = 0;
      do begin tick(); k++; end while (!ps_o && k < 100);
   endtask

   task automatic cap(input int n, output logic [31:0] bm, output logic [31:0] bn,
                      output logic [31:0] b0, output logic [31:0] b1, output logic [31:0] bp);
      bm = '0; bn = '0; b0 = '0; b1 = '0; bp = '0;
      wait_ps();
      for (int k = 0; k < n; k++) begin
         bm[k] = mod_o; bn[k] = modn_o; b0[k] = modl_o[0]; b1[k] = modl_o[1]; bp[k] = ps_o;
         tick();
      end
   endtask

   task automatic count_events(input int n, output int n_ack, output int n_ps, output int n_mod);
      n_ack = 0; n_ps = 0; n_mod = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         n_ack += int'(cfg_if.CFG_ACK); n_ps += int'(ps_o); n_mod += int'(mod_o);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] bm, bn, b0, b1, bp;
      int k, na, np, nm;
      cfg_if.CFG_LOAD = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(negedge clk);
      chk("RST_MOD", mod_o, 0);
      chk("RST_MODN", modn_o, 0);
      chk("RST_MODL", modl_o, 0);
      chk("RST_PS", ps_o, 0);
      chk("RST_ACK", cfg_if.CFG_ACK, 0);
      rst_n = 1'b1;
      repeat (4) tick();

      // reference waveform
      load_cfg(9, 5, 1, 0, 3);
      enable = 1'b1;
      cap(10, bm, bn, b0, b1, bp);
      chk("PAT_MOD", bm, 32'h01F);
      chk("PAT_MODN", bn, 32'h1C0);
      chk("PAT_L0", b0, 32'h01F);
      chk("PAT_L1", b1, 32'h0F8);
      chk("PAT_PS", bp, 32'h001);
      chk("PAT_PS_NEXT", ps_o, 1);

      // reload mid-period, takes effect at wrap
      wait_ps(); repeat (3) tick();
      load_now(3, 2, 0, 0, 1);
      ticks_to_ack(k);
      chk("ACK_LAT_MID", k, 5);
      wait_ps(); ticks_to_ps(k);
      chk("NEW_PERIOD", k, 4);

      // load exactly at wrap waits one more period
      load_cfg(9, 5, 1, 0, 3);
      wait_ps(); repeat (8) tick();
      load_now(9, 3, 0, 0, 0);
      ticks_to_ack(k);
      chk("ACK_LAT_WRAP", k, 10);
      cap(10, bm, bn, b0, b1, bp);
      chk("WRAP_MOD", bm, 32'h007);

      // two loads while pending: last wins, one ack
      wait_ps(); tick();
      load_now(9, 2, 0, 0, 0);
      repeat (2) tick();
      load_now(9, 7, 0, 0, 0);
      count_events(25, na, np, nm);
      chk("SINGLE_ACK", na, 1);
      cap(10, bm, bn, b0, b1, bp);
      chk("LAST_WINS_MOD", bm, 32'h07F);

      // drain completes the period then idles
      wait_ps(); tick();
      enable = 1'b0;
      count_events(20, na, np, nm);
      chk("DRAIN_PS", np, 0);
      chk("DRAIN_MOD", nm, 5);
      chk("IDLE_MOD", mod_o, 0);
      enable = 1'b1;
      wait_ps(); tick();
      enable = 1'b0;
      repeat (4) tick();
      enable = 1'b1;
      ticks_to_ps(k);
      chk("REARM_CONT", k, 5);
      ticks_to_ps(k);
      chk("REARM_PERIOD", k, 10);

      // boundaries
      load_cfg(9, 0, 1, 0, 0);
      cap(10, bm, bn, b0, b1, bp);
      chk("H0_MOD", bm, 32'h000);
      load_cfg(9, 20, 1, 0, 0);
      cap(10, bm, bn, b0, b1, bp);
      chk("HBIG_MOD", bm, 32'h3FF);
      chk("HBIG_MODN", bn, 32'h000);
      load_cfg(9, 5, 7, 0, 0);
      cap(10, bm, bn, b0, b1, bp);
      chk("DEAD_MODN", bn, 32'h000);
      chk("DEAD_MOD", bm, 32'h01F);
      load_cfg(0, 1, 0, 0, 0);
      cap(4, bm, bn, b0, b1, bp);
      chk("P0_PS", bp, 32'h5);
      chk("P0_MOD", bm, 32'h5);
      chk("P0_MODN", bn, 32'hA);
      load_cfg(9, 5, 0, 0, 20);
      cap(10, bm, bn, b0, b1, bp);
      chk("PH_CLAMP", b1, 32'h20F);

      // asynchronous reset mid-period with a load pending
      load_cfg(9, 5, 1, 0, 3);
      wait_ps(); repeat (3) tick();
      load_now(4, 1, 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("ARST_MOD", mod_o, 0);
      chk("ARST_MODL", modl_o, 0);
      chk("ARST_PS", ps_o, 0);
      chk("ARST_ACK", cfg_if.CFG_ACK, 0);
      @(negedge clk);
      model_reset();
      rst_n = 1'b1;
      count_events(20, na, np, nm);
      chk("ARST_NOACK", na, 0);
      wait_ps(); ticks_to_ps(k);
      chk("ARST_DEF_P", k, 2);
      cap(2, bm, bn, b0, b1, bp);
      chk("ARST_DEF_MOD", bm, 32'h1);

      // random soak
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 99) < 4) enable = ~enable;
         if ($urandom_range(0, 99) < 5) begin
            set_cfg($urandom_range(0, 15), $urandom_range(0, 18), $urandom_range(0, 15),
                    $urandom_range(0, 20), $urandom_range(0, 20));
            cfg_if.CFG_LOAD = 1'b1;
         end else begin
            cfg_if.CFG_LOAD = 1'b0;
         end
         tick();
      end
      cfg_if.CFG_LOAD = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/mod_signal_gen_multi.md
MOD_SIGNAL_GEN_MULTI -- requirements
Module: mod_signal_gen_multi

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the period, duty and phase counters.
REQ-002 SHALL have parameter NUM_LIGHT, default 2: number of independent light-source (CLKL) channels.
REQ-003 SHALL have parameter DEAD_W, default 4: width of the dead-time field.
REQ-004 SHALL have port CLK_IN  input  1  single clock; all logic in this domain.
REQ-005 SHALL have port RESET_B  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port ENABLE  input  1  run request; level-sensitive.
REQ-007 SHALL have port PERIOD  input  CNT_W  period minus one, so P = PERIOD+1 clocks; PERIOD=0 is treated as 1.
REQ-008 SHALL have port HIGH_CNT  input  CNT_W  CLK high time in clocks; H = min(HIGH_CNT, P).
REQ-009 SHALL have port DEAD  input  DEAD_W  non-overlap gap D in clocks between CLK and CLKN edges.
REQ-010 SHALL have port PHASE  input  NUM_LIGHT*CNT_W  per-channel CLKL delay PH_i (channel i in bits [i*CNT_W +: CNT_W]); values >= P are clamped to P-1.
REQ-011 SHALL have port CFG_LOAD  input  1  one-cycle pulse that captures PERIOD/HIGH_CNT/DEAD/PHASE into staging.
REQ-012 SHALL have port CFG_ACK  output  1  one-cycle pulse: staged config now active.
REQ-013 SHALL have port CLK_OUT_MOD  output  1  modulation clock.
REQ-014 SHALL have port CLK_OUT_MODN  output  1  non-overlapping complement.
REQ-015 SHALL have port CLK_OUT_MODL  output  NUM_LIGHT  light-source clocks.
REQ-016 SHALL have port PERIOD_START  output  1  one-cycle pulse, aligned with the output cycle for cnt=0.

Function
REQ-017 SHALL keep a counter cnt that runs 0..P-1 and wraps to 0 in states RUN and DRAIN, and is held at 0 in IDLE.
REQ-018 SHALL register all outputs: outputs in cycle t+1 decode cnt(t) and the active config; latency is 1 clock.
REQ-019 CLK_OUT_MOD SHALL be 1 iff cnt < H.
REQ-020 CLK_OUT_MODN SHALL be 1 iff H+D <= cnt < P-D, computed with CNT_W+1-bit arithmetic; an empty range gives constant 0, and MODN and MOD are never 1 in the same cycle.
REQ-021 CLK_OUT_MODL[i] SHALL be 1 iff ((cnt - PH_i) mod P) < H; the modulo SHALL be implemented as a conditional add of P, with no divider.
REQ-022 PERIOD_START SHALL be 1 in the output cycle decoded from cnt=0 while in RUN or DRAIN.
REQ-023 FSM states: IDLE, RUN, DRAIN.
- IDLE->RUN: on ENABLE=1; first decoded cnt is 0.
- RUN->DRAIN: on ENABLE=0.
- DRAIN->RUN: on ENABLE=1; the counter continues without restart.
- DRAIN->IDLE: at wrap (cnt=P-1); the full period completes.
REQ-024 In IDLE, all waveform outputs and PERIOD_START SHALL be 0.
REQ-025 CFG_LOAD SHALL copy the inputs into staging and set a pending flag.
REQ-026 Pending config SHALL be applied in RUN/DRAIN only in the wrap cycle (cnt=P-1), so it takes effect from cnt=0. In IDLE it SHALL be applied in the cycle after it becomes pending.
REQ-027 CFG_ACK SHALL pulse for exactly one cycle, the cycle after the apply, and the pending flag SHALL clear at apply.
REQ-028 A CFG_LOAD while pending SHALL overwrite staging and produce a single CFG_ACK.
REQ-029 A CFG_LOAD in the wrap cycle SHALL be applied at the following wrap, not the current one.
REQ-030 CFG_LOAD asserted in the same cycle as an apply SHALL win: staging is overwritten and pending stays set.
REQ-031 The active config SHALL never change mid-period, so no output glitches or runt pulses occur on reconfiguration.

Reset
REQ-032 RESET_B=0 SHALL asynchronously force:
- state IDLE, cnt 0, pending 0;
- all outputs 0;
- active config PERIOD=1, HIGH_CNT=1, DEAD=0, PHASE=0;
- staging all 0.
REQ-033 RESET_B=0 mid-period SHALL immediately force outputs to 0, with no drain.
REQ-034 Release of RESET_B SHALL be synchronised internally (2-flop) before it affects the FSM.

Verification
REQ-035 Config PERIOD=9, HIGH_CNT=5, DEAD=1, PHASE={3,0}, then ENABLE=1 -> MOD high cycles 0-4, MODN high cycles 6-8, MODL[0] high 0-4, MODL[1] high 3-7, PERIOD_START every 10 clocks.
REQ-036 Running P=10, then CFG_LOAD with PERIOD=3 at cnt=4 -> old waveform until cnt=9, CFG_ACK one cycle later, next period is 4 clocks; also CFG_LOAD exactly at cnt=9 -> applied one period later.
REQ-037 ENABLE dropped at cnt=2 of P=10 -> outputs continue through cnt=9, then all 0, IDLE; ENABLE re-raised at cnt=6 -> no interruption.
REQ-038 Boundaries: HIGH_CNT=0 -> MOD constant 0; HIGH_CNT>=P -> MOD constant 1 and MODN 0; DEAD large enough to empty the range -> MODN 0; PERIOD=0 -> P=2; PHASE=20 with P=10 -> clamped to 9.
REQ-039 Assert RESET_B=0 mid-period -> outputs 0 in the same cycle, active config at defaults, no CFG_ACK after release; a random-config soak SHALL check that MOD and MODN are never 1 together.
